// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - switch synchronizer and per-bit tick-sampled debouncer
//
// Conditions raw active-low slide switch levels into the clk domain and
// presents a settled word to the adder input stage.
//
// Ports:
//   clk     system clock, rising edge
//   rst     asynchronous active-high reset
//   sw_raw  [WIDTH] raw switch levels, asynchronous, active-low (off = 1)
//   sw_a    [WIDTH] debounced switch word, resets to all ones (all off)
//   sw_chg  one-cycle pulse in the first cycle sw_a shows a new value
//   tick    one-cycle sample strobe every TICK_DIV cycles
module sw_debounce #(
    parameter int WIDTH    = 32,
    parameter int TICK_DIV = 50000,
    parameter int STABLE_N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_a,
    output logic             sw_chg,
    output logic             tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(STABLE_N + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_N - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [PW-1:0]    pre;
    logic [CW-1:0]    cnt [WIDTH];
    logic [WIDTH-1:0] differ;
    logic [WIDTH-1:0] commit;

    // Two-flop synchronizer; resets to "all switches off".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;
        end
    end

    // Prescaler; tick is registered so it lands one cycle after the wrap value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (pre == PRE_LAST);
            pre  <= (pre == PRE_LAST) ? '0 : pre + 1'b1;
        end
    end

    // A bit commits when it still differs and this is its STABLE_N-th
    // consecutive differing sample.
    always_comb begin
        differ = sync2 ^ sw_a;
        commit = '0;
        for (int i = 0; i < WIDTH; i++) begin
            commit[i] = differ[i] && (cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_a   <= '1;
            sw_chg <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            // One strobe no matter how many bits commit together.
            sw_chg <= tick && (|commit);
            if (tick) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (!differ[i]) begin
                        // An agreeing sample cancels any pending change.
                        cnt[i] <= '0;
                    end else if (commit[i]) begin
                        sw_a[i] <= sync2[i];
                        cnt[i]  <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sw_debounce.sv
// tb/tb_sw_debounce.sv - self-checking bench for sw_debounce
module tb_sw_debounce;

    localparam int W  = 32;
    localparam int TD = 4;
    localparam int SN = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] sw_raw = '1;
    logic [W-1:0] sw_a;
    logic         sw_chg;
    logic         tick;

    always #5 clk = ~clk;

    sw_debounce #(.WIDTH(W), .TICK_DIV(TD), .STABLE_N(SN)) dut (
        .clk    (clk),
        .rst    (rst),
        .sw_raw (sw_raw),
        .sw_a   (sw_a),
        .sw_chg (sw_chg),
        .tick   (tick)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int chg_seen = 0;

    // Reference model: remembers every raw value seen at a clock edge since
    // reset and the list of tick-time samples; a bit takes a new level once
    // its last SN samples all disagree with the current level.
    int unsigned  edges;
    logic [W-1:0] raw_hist[$];
    logic [W-1:0] samples[$];
    logic [W-1:0] m_a;
    logic         m_chg;
    logic         m_tick;
    logic [W-1:0] m_s;
    logic [W-1:0] m_com;
    bit           all_diff;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            edges = 0;
            raw_hist.delete();
            samples.delete();
            m_a    = '1;
            m_chg  = 1'b0;
            m_tick = 1'b0;
        end else begin
            edges++;
            raw_hist.push_back(sw_raw);
            m_chg = 1'b0;
            // Sample edges are the ones following each TD-cycle interval.
            if (edges > 1 && ((edges - 1) % TD) == 0) begin
                // Value seen through two synchronizer stages: raw from two edges ago.
                m_s = raw_hist[edges - 3];
                samples.push_back(m_s);
                m_com = '0;
                if (samples.size() >= SN) begin
                    for (int b = 0; b < W; b++) begin
                        all_diff = 1'b1;
                        for (int j = 0; j < SN; j++) begin
                            if (samples[samples.size() - 1 - j][b] == m_a[b]) all_diff = 1'b0;
                        end
                        m_com[b] = all_diff;
                    end
                end
                m_a   = m_a ^ m_com;
                m_chg = |m_com;
            end
            m_tick = ((edges % TD) == 0);
        end
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("sw_a", sw_a, m_a);
        chk("sw_chg", W'(sw_chg), W'(m_chg));
        chk("tick", W'(tick), W'(m_tick));
        if (sw_chg === 1'b1) chg_seen++;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            check_model();
        end
    endtask

    int  e_step;
    int  lat;
    int  chg0;
    int  tog;
    logic prev;
    int  r;

    initial begin
        // Reset state
        #1 rst = 1'b1;
        #1;
        chk("rst_sw_a", sw_a, '1);
        chk("rst_sw_chg", W'(sw_chg), '0);
        chk("rst_tick", W'(tick), '0);
        cyc(3);
        rst = 1'b0;
        cyc(20);

        // Clean change
        chg0 = chg_seen;
        sw_raw = 32'hFFFF_FF00;
        e_step = edges;
        lat = -1;
        for (int i = 0; i < 30; i++) begin
            cyc(1);
            if (lat < 0 && sw_a === 32'hFFFF_FF00) lat = int'(edges) - e_step;
        end
        chk("clean_latency_in_11_14", W'(lat >= 11 && lat <= 14), W'(1));
        chk("clean_chg_pulses", W'(chg_seen - chg0), W'(1));

        // Async reset between edges
        chk("pre_rst_sw_a", sw_a, 32'hFFFF_FF00);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_sw_a", sw_a, 32'hFFFF_FFFF);
        chk("async_rst_sw_chg", W'(sw_chg), '0);
        cyc(2);
        rst = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            cyc(1);
            chk("tick_phase", W'(tick), W'((i % TD) == 0));
        end
        sw_raw = '1;
        cyc(30);

        // Glitch rejection
        chg0 = chg_seen;
        sw_raw[0] = 1'b0;
        cyc(8);
        sw_raw[0] = 1'b1;
        cyc(20);
        chk("glitch_sw_a", sw_a, 32'hFFFF_FFFF);
        chk("glitch_chg", W'(chg_seen - chg0), '0);

        // Bounce
        chg0 = chg_seen;
        tog = 0;
        prev = sw_a[16];
        for (int i = 0; i < 30; i++) begin
            if (i % 3 == 0) sw_raw[16] = ~sw_raw[16];
            cyc(1);
            if (sw_a[16] !== prev) tog++;
            prev = sw_a[16];
        end
        sw_raw[16] = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (sw_a[16] !== prev) tog++;
            prev = sw_a[16];
        end
        chk("bounce_toggles", W'(tog), W'(1));
        chk("bounce_chg", W'(chg_seen - chg0), W'(1));
        chk("bounce_final", W'(sw_a[16]), '0);

        // Simultaneous bits
        chg0 = chg_seen;
        sw_raw[0] = 1'b0;
        sw_raw[8] = 1'b0;
        for (int i = 0; i < 25; i++) begin
            cyc(1);
            chk("simul_same_edge", W'(sw_a[0]), W'(sw_a[8]));
        end
        chk("simul_chg", W'(chg_seen - chg0), W'(1));
        chk("simul_bits", W'(sw_a[8] | sw_a[0]), '0);
        chg0 = chg_seen;
        sw_raw[2] = 1'b0;
        cyc(2);
        sw_raw[1] = 1'b0;
        cyc(25);
        chk("stagger_chg_1_or_2", W'((chg_seen - chg0) >= 1 && (chg_seen - chg0) <= 2), W'(1));
        chk("stagger_bits", W'(sw_a[2:0]), '0);

        // Abort by agreement
        sw_raw[3] = 1'b0;
        cyc(8);
        sw_raw[3] = 1'b1;
        cyc(4);
        chk("abort_hold", W'(sw_a[3]), W'(1));
        sw_raw[3] = 1'b0;
        e_step = edges;
        lat = -1;
        for (int i = 0; i < 30; i++) begin
            cyc(1);
            if (lat < 0 && sw_a[3] === 1'b0) lat = int'(edges) - e_step;
        end
        chk("abort_latency_ge_11", W'(lat >= 11 && lat <= 14), W'(1));

        // Randomized traffic against the model, with one reset mid-stream
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            check_model();
            if (c == 700) begin
                #2 rst = 1'b1;
                #1;
                chk("rand_rst_sw_a", sw_a, '1);
            end
            if (c == 705) rst = 1'b0;
            r = int'($urandom_range(0, 15));
            if (r == 0) begin
                sw_raw[$urandom_range(0, W - 1)] = ~sw_raw[$urandom_range(0, W - 1)];
            end else if (r == 1) begin
                sw_raw = sw_raw ^ ((32'h1 << $urandom_range(0, W - 1)) | (32'h1 << $urandom_range(0, W - 1)));
            end else if (r == 2) begin
                sw_raw = ~sw_raw;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sw_debounce.md
# sw_debounce

Input conditioning stage that sits between the board's slide switches and `adpt_in`. It synchronizes the raw, active-low switch levels into the `clk` domain and debounces each bit independently. It then drives a stable 32-bit `sw_a` word, so the adder datapath only ever sees settled operands and carry-in. It also emits a single-cycle strobe whenever the debounced word changes, for downstream capture or display refresh.

## Interface
- `WIDTH`, default 32: number of switch bits conditioned.
- `TICK_DIV`, default 50000: clk cycles per debounce sample (1 ms at 50 MHz); must be ≥ 2.
- `STABLE_N`, default 4: consecutive differing samples required to commit a new level; must be ≥ 1.

Ports:
- `clk`  in  1  single system clock; all state is on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `sw_raw`  in  WIDTH  raw physical switch levels, asynchronous to `clk`, active-low (switch off = 1).
- `sw_a`  out  WIDTH  debounced switch word; connects directly to `adpt_in.sw_a`.
- `sw_chg`  out  1  one-cycle pulse on the edge where any bit of `sw_a` changes.
- `tick`  out  1  sample strobe, one cycle wide, every `TICK_DIV` cycles.

## Operation
- **Reset values.** `rst` high forces the following immediately, with no clock needed: `sw_a` = all ones, both synchronizer stages = all ones, prescaler = 0, all per-bit counters = 0, `sw_chg` = 0, `tick` = 0. All ones means every switch is off, so `adpt_in` presents zero operands and K = 0.
- **Synchronizer.** A two-flop synchronizer per bit: `sync1 <= sw_raw`, `sync2 <= sync1`. Only `sync2` is used after this point.
- **Prescaler.**
  - Counter `pre` counts 0 … `TICK_DIV`−1 and wraps to 0.
  - The registered `tick` is 1 in the cycle after `pre` == `TICK_DIV`−1 is sampled, and 0 otherwise.
- **Per-bit debounce.** Each bit i has a saturating counter `cnt[i]` of width clog2(`STABLE_N`+1). It updates only on clock edges where `tick` = 1:
  - If `sync2[i]` == `sw_a[i]`: `cnt[i]` <= 0, because any agreeing sample aborts a pending change.
  - Otherwise, if `cnt[i]` == `STABLE_N`−1: `sw_a[i]` <= `sync2[i]` and `cnt[i]` <= 0 (commit).
  - Otherwise: `cnt[i]` <= `cnt[i]`+1.
  - When `tick` = 0, all counters and `sw_a` hold.
- **Change strobe.** `sw_chg` <= `tick` AND (any bit commits on this edge). It is registered, so it is high in exactly the cycle in which `sw_a` first shows the new value.
- **Simultaneous commits.** Multiple bits committing on the same tick produce one `sw_chg` pulse.
- **Minimum `STABLE_N`.** With `STABLE_N` = 1, a bit commits on the first tick that samples a differing level.
- **Bit independence.** Bits are fully independent. A bouncing bit never delays or blocks a neighbour.

## Timing
- Synchronizer latency is 2 clk edges.
- Commit latency for a clean, held `sw_raw` edge is between (`STABLE_N`−1)·`TICK_DIV`+3 and `STABLE_N`·`TICK_DIV`+2 clk edges, measured from the raw transition to `sw_a` updating. The exact value depends on prescaler phase.
- Glitch rejection:
  - A level held for fewer than `STABLE_N` consecutive ticks never reaches `sw_a`.
  - A level held for ≥ `STABLE_N`·`TICK_DIV`+2 cycles always reaches `sw_a`.
- After `rst` deasserts, the first `tick` occurs `TICK_DIV` cycles later, and then every `TICK_DIV` cycles.
- **Reset mid-count.** Pending counts are discarded and `sw_a` returns to all ones immediately. A switch that is held on must then requalify from scratch.
- Output is registered only: there is no combinational path from `sw_raw` to `sw_a`, `sw_chg` or `tick`.

## Test plan
All scenarios use `TICK_DIV` = 4 and `STABLE_N` = 3.
1. **Async reset.** Assert `rst` between clock edges while `sw_a` = 32'hFFFF_FF00 → `sw_a` = 32'hFFFF_FFFF and `sw_chg` = 0 before the next edge. Release `rst` → `tick` first pulses 4 cycles later, then every 4 cycles.
2. **Clean change.** Step `sw_raw` from 32'hFFFF_FFFF to 32'hFFFF_FF00 and hold → `sw_a` = 32'hFFFF_FF00 between 11 and 14 edges after the step. `sw_chg` is high for exactly that one cycle.
3. **Glitch rejection.** Drive `sw_raw[0]` = 0 for 8 cycles (2 ticks), then back to 1 → `sw_a` stays 32'hFFFF_FFFF and `sw_chg` never pulses.
4. **Bounce.** Toggle `sw_raw[16]` every 3 cycles for 30 cycles, then hold it at 0 → `sw_a[16]` goes 1→0 exactly once, with exactly one `sw_chg` pulse. No intermediate toggles appear on `sw_a`.
5. **Simultaneous bits.** Clear `sw_raw[0]` and `sw_raw[8]` on the same cycle → both bits change on the same edge and `sw_chg` pulses once. Then clear `sw_raw[1]` 2 cycles after `sw_raw[2]` → both commit (same or adjacent tick) with one `sw_chg` pulse per commit edge.
6. **Abort by agreement.** Clear `sw_raw[3]` for 2 ticks, restore it for 1 tick, then clear it again and hold → the commit occurs only after 3 fresh differing ticks. The total delay from the second clear is ≥ 11 edges.
